// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory port between instruction fetch and load/store.
// Optional grant/wait performance counters are enabled with MEM_PORT_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          ls_req_i,
  input  logic          ls_wr_i,
  input  logic [7:0]    ls_bytes_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [DW-1:0] ls_wdata_i,
  output logic          ls_ack_o,
  output logic [DW-1:0] ls_rdata_o,
  output logic          mem_req_o,
  output logic          mem_wr_o,
  output logic [7:0]    mem_bytes_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic [31:0]   perf_if_cnt_o,
  output logic [31:0]   perf_ls_cnt_o,
  output logic [31:0]   perf_wait_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_e;

  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  state_e          state_q, state_d;
  logic [3:0]      starve_q, starve_d;
  logic            grant_if, grant_ls;
  logic            mem_req_q, mem_req_d;
  logic            mem_wr_q, mem_wr_d;
  logic [7:0]      mem_bytes_q, mem_bytes_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_ls) begin
          state_d = BUSY_LS;
        end else if (grant_if) begin
          state_d = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // LS wins contention unless IF has been passed over STARVE_LIM times in a row.
  always_comb begin
    grant_ls = (state_q == IDLE) && ls_req_i && !(if_req_i && (starve_q == StarveLim));
    grant_if = (state_q == IDLE) && if_req_i && !grant_ls;
    if_ack_o = (state_q == BUSY_IF) && mem_ack_i;
    ls_ack_o = (state_q == BUSY_LS) && mem_ack_i;
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = 4'd0;
    end else if (grant_ls && if_req_i && (starve_q != StarveLim)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_bytes_d = mem_bytes_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (grant_ls) begin
      mem_req_d   = 1'b1;
      mem_wr_d    = ls_wr_i;
      mem_bytes_d = ls_bytes_i;
      mem_addr_d  = ls_addr_i;
      mem_wdata_d = ls_wdata_i;
    end else if (grant_if) begin
      mem_req_d   = 1'b1;
      mem_wr_d    = 1'b0;
      mem_bytes_d = 8'h0f;
      mem_addr_d  = if_addr_i;
      mem_wdata_d = '0;
    end else if (mem_req_q && mem_ack_i) begin
      mem_req_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_bytes_q <= 8'h00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_bytes_q <= mem_bytes_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_bytes_o = mem_bytes_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_ls_q, perf_ls_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_if_d   = perf_if_q + {31'd0, grant_if};
    perf_ls_d   = perf_ls_q + {31'd0, grant_ls};
    perf_wait_d = perf_wait_q + {31'd0, (if_req_i | ls_req_i) & ~(if_ack_o | ls_ack_o)};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_if_q   <= 32'd0;
      perf_ls_q   <= 32'd0;
      perf_wait_q <= 32'd0;
    end else begin
      perf_if_q   <= perf_if_d;
      perf_ls_q   <= perf_ls_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_if_cnt_o   = perf_if_q;
  assign perf_ls_cnt_o   = perf_ls_q;
  assign perf_wait_cnt_o = perf_wait_q;
`else
  assign perf_if_cnt_o   = 32'd0;
  assign perf_ls_cnt_o   = 32'd0;
  assign perf_wait_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table plus hand-written
// store, contention, dropped-request, reset and perf-counter sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ifReq;
  logic [63:0] ifAddr;
  logic        ifAck;
  logic [63:0] ifRdata;
  logic        lsReq;
  logic        lsWr;
  logic [7:0]  lsBytes;
  logic [63:0] lsAddr;
  logic [63:0] lsWdata;
  logic        lsAck;
  logic [63:0] lsRdata;
  logic        memReq;
  logic        memWr;
  logic [7:0]  memBytes;
  logic [63:0] memAddr;
  logic [63:0] memWdata;
  logic [63:0] memRdata;
  logic        memAck;
  logic [31:0] perfIfCnt;
  logic [31:0] perfLsCnt;
  logic [31:0] perfWaitCnt;

  int checks = 0;
  int passes = 0;

  mem_port_arbiter #(.AW(64), .DW(64), .STARVE_LIM(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_ack_o(ifAck), .if_rdata_o(ifRdata),
    .ls_req_i(lsReq), .ls_wr_i(lsWr), .ls_bytes_i(lsBytes), .ls_addr_i(lsAddr),
    .ls_wdata_i(lsWdata), .ls_ack_o(lsAck), .ls_rdata_o(lsRdata),
    .mem_req_o(memReq), .mem_wr_o(memWr), .mem_bytes_o(memBytes), .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata), .mem_rdata_i(memRdata), .mem_ack_i(memAck),
    .perf_if_cnt_o(perfIfCnt), .perf_ls_cnt_o(perfLsCnt), .perf_wait_cnt_o(perfWaitCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifReq;
    logic        lsReq;
    logic        memAck;
    logic [63:0] rdata;
    logic        expMemReq;
    logic        expMemWr;
    logic [7:0]  expMemBytes;
    logic        expIfAck;
    logic        expLsAck;
  } vec_t;

  vec_t vecs[11];

  // Drive inputs just after an edge so outputs can be sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ifReq    = v.ifReq;
    lsReq    = v.lsReq;
    memAck   = v.memAck;
    memRdata = v.rdata;
  endtask

  task automatic runTxn(input logic isLs);
    ifReq  = ~isLs;
    lsReq  = isLs;
    memAck = 1'b0;
    tick();
    memAck = 1'b1;
    tick();
    ifReq  = 1'b0;
    lsReq  = 1'b0;
    memAck = 1'b0;
    tick();
  endtask

  logic [7:0] grantOrder[10];
  int grants;
  int ackCount;
  logic prevReq;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 64'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 64'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 64'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 64'h44, 1'b1, 1'b0, 8'h0f, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 64'h55, 1'b1, 1'b0, 8'h0f, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 64'h66, 1'b1, 1'b0, 8'h0f, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 64'h77, 1'b1, 1'b0, 8'h0f, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h88, 1'b0, 1'b0, 8'h0f, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 64'h99, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 64'haa, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 64'hbb, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};

    grantOrder = '{8'hff, 8'hff, 8'hff, 8'hff, 8'h0f, 8'hff, 8'hff, 8'hff, 8'hff, 8'h0f};

    rst      = 1'b1;
    ifReq    = 1'b0;
    ifAddr   = 64'h8000_0000;
    lsReq    = 1'b0;
    lsWr     = 1'b1;
    lsBytes  = 8'h03;
    lsAddr   = 64'h8000_1002;
    lsWdata  = 64'hBEEF;
    memRdata = 64'h0;
    memAck   = 1'b0;
    tick();
    tick();
    checkOutput("reset mem_req", {63'd0, memReq}, 64'd0);
    checkOutput("reset mem_addr", memAddr, 64'd0);
    checkOutput("reset mem_wdata", memWdata, 64'd0);
    checkOutput("reset mem_bytes", {56'd0, memBytes}, 64'd0);
    checkOutput("reset perf_wait", {32'd0, perfWaitCnt}, 64'd0);
    rst = 1'b0;

    // Stray ack, single fetch with 3-cycle latency, then a short store.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d mem_req", i), {63'd0, memReq}, {63'd0, vecs[i].expMemReq});
      checkOutput($sformatf("vec%0d mem_wr", i), {63'd0, memWr}, {63'd0, vecs[i].expMemWr});
      checkOutput($sformatf("vec%0d mem_bytes", i), {56'd0, memBytes}, {56'd0, vecs[i].expMemBytes});
      checkOutput($sformatf("vec%0d if_ack", i), {63'd0, ifAck}, {63'd0, vecs[i].expIfAck});
      checkOutput($sformatf("vec%0d ls_ack", i), {63'd0, lsAck}, {63'd0, vecs[i].expLsAck});
      checkOutput($sformatf("vec%0d if_rdata", i), ifRdata, vecs[i].rdata);
      checkOutput($sformatf("vec%0d ls_rdata", i), lsRdata, vecs[i].rdata);
      tick();
    end

    // Store fields latched at grant and held stable until mem_ack.
    lsReq  = 1'b1;
    memAck = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("store c%0d mem_req", c), {63'd0, memReq}, 64'd1);
      checkOutput($sformatf("store c%0d mem_wr", c), {63'd0, memWr}, 64'd1);
      checkOutput($sformatf("store c%0d mem_bytes", c), {56'd0, memBytes}, 64'h03);
      checkOutput($sformatf("store c%0d mem_addr", c), memAddr, 64'h8000_1002);
      checkOutput($sformatf("store c%0d mem_wdata", c), memWdata, 64'hBEEF);
      checkOutput($sformatf("store c%0d ls_ack", c), {63'd0, lsAck}, 64'd0);
      tick();
    end
    memAck = 1'b1;
    #1;
    checkOutput("store ls_ack", {63'd0, lsAck}, 64'd1);
    tick();
    lsReq  = 1'b0;
    memAck = 1'b0;
    #1;
    checkOutput("store ls_ack after", {63'd0, lsAck}, 64'd0);
    checkOutput("store mem_req after", {63'd0, memReq}, 64'd0);
    tick();

    // Contention: both requesters held, memory acks in the first mem_req cycle.
    lsWr    = 1'b0;
    lsBytes = 8'hff;
    lsAddr  = 64'h8000_2000;
    ifReq   = 1'b1;
    lsReq   = 1'b1;
    grants  = 0;
    prevReq = 1'b0;
    for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
      memAck = memReq;
      #1;
      if (memReq && !prevReq) begin
        checkOutput($sformatf("contend grant%0d bytes", grants), {56'd0, memBytes}, {56'd0, grantOrder[grants]});
        checkOutput($sformatf("contend grant%0d addr", grants), memAddr,
                    (grantOrder[grants] == 8'h0f) ? 64'h8000_0000 : 64'h8000_2000);
        grants++;
      end
      prevReq = memReq;
      tick();
    end
    checkOutput("contend grant count", 64'(grants), 64'd10);
    ifReq  = 1'b0;
    lsReq  = 1'b0;
    memAck = 1'b0;
    tick();

    // Request dropped after grant still completes with exactly one ack.
    lsReq  = 1'b1;
    tick();
    lsReq  = 1'b0;
    ackCount = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      ackCount += int'(lsAck);
      tick();
    end
    memAck = 1'b1;
    #1;
    checkOutput("drop ls_ack", {63'd0, lsAck}, 64'd1);
    ackCount += int'(lsAck);
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      checkOutput($sformatf("stray c%0d if_ack", c), {63'd0, ifAck}, 64'd0);
      ackCount += int'(lsAck);
      tick();
    end
    memAck = 1'b0;
    checkOutput("drop ack count", 64'(ackCount), 64'd1);

    // Reset while BUSY_LS drops the access with no ack.
    lsReq = 1'b1;
    tick();
    checkOutput("pre-reset mem_req", {63'd0, memReq}, 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid-reset mem_req", {63'd0, memReq}, 64'd0);
    checkOutput("mid-reset mem_addr", memAddr, 64'd0);
    checkOutput("mid-reset perf_ls", {32'd0, perfLsCnt}, 64'd0);
    rst    = 1'b0;
    lsReq  = 1'b0;
    memAck = 1'b1;
    #1;
    checkOutput("post-reset ls_ack", {63'd0, lsAck}, 64'd0);
    tick();
    memAck = 1'b0;
    tick();

    // Three fetches and two loads, each grant then ack.
    runTxn(1'b0);
    runTxn(1'b1);
    runTxn(1'b0);
    runTxn(1'b1);
    runTxn(1'b0);
`ifdef MEM_PORT_ARB_PERF_EN
    checkOutput("perf_if_cnt", {32'd0, perfIfCnt}, 64'd3);
    checkOutput("perf_ls_cnt", {32'd0, perfLsCnt}, 64'd2);
    checkOutput("perf_wait_cnt", {32'd0, perfWaitCnt}, 64'd5);
`else
    checkOutput("perf_if_cnt", {32'd0, perfIfCnt}, 64'd0);
    checkOutput("perf_ls_cnt", {32'd0, perfLsCnt}, 64'd0);
    checkOutput("perf_wait_cnt", {32'd0, perfWaitCnt}, 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
